// File: rtl/layer_sched.sv
// Layer/sprite pixel arbiter with a frame-counted sprite animation phase.
// Grants are registered one-hot; the sprite grant is steered by the current phase.
module layer_sched #(
  parameter int DIV_W   = 8,
  parameter int DIV_RST = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vs_start,
  input  logic             de,
  input  logic [4:0]       hit,
  input  logic             cfg_we,
  input  logic [4:0]       cfg_mask,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             RqFLag0,
  output logic             RqFLag1,
  output logic             RqFLag2,
  output logic             RqFLag3,
  output logic             RqFLag4,
  output logic             RqFLag5,
  output logic [1:0]       phase
);

  typedef enum logic [1:0] {
    BLANK  = 2'b00,
    SHOW_A = 2'b01,
    SHOW_B = 2'b10
  } state_t;

  state_t           state, state_next;
  logic [DIV_W-1:0] frame_cnt, cnt_next;
  logic [DIV_W-1:0] div_active, div_staged;
  logic [DIV_W-1:0] div_sel, div_lim;
  logic [4:0]       mask;
  logic [4:0]       req;
  logic [5:0]       grant, grant_next;

  // A write landing on the same vs_start takes effect immediately.
  assign div_sel = cfg_we ? cfg_div : div_staged;
  assign div_lim = (div_sel == '0) ? '0 : div_sel - 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BLANK;
    else     state <= state_next;
  end

  // The >= compare lets a lowered divider toggle at once instead of wrapping.
  always_comb begin
    state_next = state;
    cnt_next   = frame_cnt;
    if (vs_start) begin
      case (state)
        BLANK: state_next = SHOW_A;
        SHOW_A, SHOW_B: begin
          if (frame_cnt >= div_lim) begin
            cnt_next   = '0;
            state_next = (state == SHOW_A) ? SHOW_B : SHOW_A;
          end else begin
            cnt_next = frame_cnt + 1'b1;
          end
        end
        default: state_next = BLANK;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt  <= '0;
      div_active <= DIV_W'(DIV_RST);
      div_staged <= DIV_W'(DIV_RST);
      mask       <= 5'b11111;
    end else begin
      frame_cnt <= cnt_next;
      if (cfg_we) begin
        mask       <= cfg_mask;
        div_staged <= cfg_div;
      end
      if (vs_start) div_active <= div_sel;
    end
  end

  // Arbitration always sees the pre-transition state for this pixel.
  assign req = hit & mask & {5{de}};

  always_comb begin
    grant_next = '0;
    if (state != BLANK) begin
      if      (req[0]) grant_next[0] = 1'b1;
      else if (req[1]) grant_next[1] = 1'b1;
      else if (req[4]) begin
        if (state == SHOW_B) grant_next[5] = 1'b1;
        else                 grant_next[4] = 1'b1;
      end
      else if (req[3]) grant_next[3] = 1'b1;
      else if (req[2]) grant_next[2] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) grant <= '0;
    else     grant <= grant_next;
  end

  assign {RqFLag5, RqFLag4, RqFLag3, RqFLag2, RqFLag1, RqFLag0} = grant;
  assign phase = state;

endmodule

// File: tb/tb_layer_sched.sv
// Directed bench for layer_sched: arbitration table plus phase/divider/reset sequences.
module tb_layer_sched;

  localparam int DIV_W = 8;

  logic             clk, rst, vs_start, de, cfg_we;
  logic [4:0]       hit, cfg_mask;
  logic [DIV_W-1:0] cfg_div;
  logic             f0, f1, f2, f3, f4, f5;
  logic [1:0]       phase;
  logic [5:0]       grants;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       we;
    logic [4:0] mask;
    logic       de;
    logic [4:0] hit;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[15];

  layer_sched #(.DIV_W(DIV_W), .DIV_RST(30)) dut (
    .clk(clk), .rst(rst), .vs_start(vs_start), .de(de), .hit(hit),
    .cfg_we(cfg_we), .cfg_mask(cfg_mask), .cfg_div(cfg_div),
    .RqFLag0(f0), .RqFLag1(f1), .RqFLag2(f2), .RqFLag3(f3),
    .RqFLag4(f4), .RqFLag5(f5), .phase(phase)
  );

  assign grants = {f5, f4, f3, f2, f1, f0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic pulse_vs();
    vs_start = 1'b1;
    tick();
    vs_start = 1'b0;
    tick();
  endtask

  initial begin
    vecs[0]  = '{1'b0, 5'b11111, 1'b1, 5'b10100, 6'b010000};
    vecs[1]  = '{1'b0, 5'b11111, 1'b1, 5'b10001, 6'b000001};
    vecs[2]  = '{1'b0, 5'b11111, 1'b1, 5'b01100, 6'b001000};
    vecs[3]  = '{1'b0, 5'b11111, 1'b1, 5'b00100, 6'b000100};
    vecs[4]  = '{1'b0, 5'b11111, 1'b1, 5'b00010, 6'b000010};
    vecs[5]  = '{1'b0, 5'b11111, 1'b1, 5'b10010, 6'b000010};
    vecs[6]  = '{1'b0, 5'b11111, 1'b1, 5'b11000, 6'b010000};
    vecs[7]  = '{1'b0, 5'b11111, 1'b1, 5'b00000, 6'b000000};
    vecs[8]  = '{1'b0, 5'b11111, 1'b0, 5'b11111, 6'b000000};
    vecs[9]  = '{1'b1, 5'b11110, 1'b1, 5'b00101, 6'b000001};
    vecs[10] = '{1'b0, 5'b11110, 1'b1, 5'b00101, 6'b000100};
    vecs[11] = '{1'b0, 5'b11110, 1'b1, 5'b10001, 6'b010000};
    vecs[12] = '{1'b0, 5'b11110, 1'b0, 5'b11111, 6'b000000};
    vecs[13] = '{1'b1, 5'b11111, 1'b1, 5'b00001, 6'b000000};
    vecs[14] = '{1'b0, 5'b11111, 1'b1, 5'b00001, 6'b000001};

    rst = 1'b1; vs_start = 1'b0; de = 1'b0; hit = '0;
    cfg_we = 1'b0; cfg_mask = 5'b11111; cfg_div = 8'd30;
    #2;
    check("reset_grants", grants, 6'b0);
    check("reset_phase", {4'b0, phase}, 6'd0);
    tick();
    rst = 1'b0;

    // Enabled hits before the first vs_start are ignored.
    de = 1'b1; hit = 5'b11111;
    tick(); tick();
    check("blank_grants", grants, 6'b0);
    check("blank_phase", {4'b0, phase}, 6'd0);
    vs_start = 1'b1;
    tick();
    vs_start = 1'b0;
    check("first_vs_phase", {4'b0, phase}, 6'd1);
    check("first_vs_grants", grants, 6'b0);
    tick();
    check("first_grant_l0", grants, 6'b000001);

    for (int i = 0; i < 15; i++) begin
      cfg_we = vecs[i].we; cfg_mask = vecs[i].mask; cfg_div = 8'd30;
      de = vecs[i].de; hit = vecs[i].hit;
      tick();
      check($sformatf("vec%0d", i), grants, vecs[i].exp);
    end
    cfg_we = 1'b0; de = 1'b0; hit = '0;

    // Divider 3: phase toggles on the third vs_start.
    cfg_we = 1'b1; cfg_mask = 5'b11111; cfg_div = 8'd3;
    tick();
    cfg_we = 1'b0;
    pulse_vs();
    check("div3_p1", {4'b0, phase}, 6'd1);
    pulse_vs();
    check("div3_p2", {4'b0, phase}, 6'd1);
    pulse_vs();
    check("div3_p3", {4'b0, phase}, 6'd2);
    de = 1'b1; hit = 5'b10000;
    tick();
    check("sprite_b", grants, 6'b100000);
    de = 1'b0; hit = '0;

    // Reach frame_cnt=20 in SHOW_B, then lower divider to 5.
    cfg_we = 1'b1; cfg_div = 8'd30;
    tick();
    cfg_we = 1'b0;
    for (int i = 0; i < 20; i++) pulse_vs();
    check("cnt20_phase", {4'b0, phase}, 6'd2);
    cfg_we = 1'b1; cfg_div = 8'd5;
    tick();
    cfg_we = 1'b0;
    pulse_vs();
    check("lowered_div_toggle", {4'b0, phase}, 6'd1);
    for (int i = 0; i < 4; i++) pulse_vs();
    check("div5_hold", {4'b0, phase}, 6'd1);
    pulse_vs();
    check("div5_toggle", {4'b0, phase}, 6'd2);

    // Divider write coincident with vs_start applies at that pulse.
    vs_start = 1'b1; cfg_we = 1'b1; cfg_div = 8'd1;
    tick();
    vs_start = 1'b0; cfg_we = 1'b0;
    check("coincident_div1", {4'b0, phase}, 6'd1);
    tick();
    vs_start = 1'b1; cfg_we = 1'b1; cfg_div = 8'd0;
    tick();
    vs_start = 1'b0; cfg_we = 1'b0;
    check("coincident_div0", {4'b0, phase}, 6'd2);
    tick();

    // vs_start with de: grant uses the pre-transition phase.
    vs_start = 1'b1; de = 1'b1; hit = 5'b10000;
    tick();
    vs_start = 1'b0;
    check("vs_de_grant", grants, 6'b100000);
    check("vs_de_phase", {4'b0, phase}, 6'd1);
    tick();
    check("vs_de_after", grants, 6'b010000);
    de = 1'b0; hit = '0;

    // Mid-frame reset in SHOW_B with a live grant and altered config.
    pulse_vs();
    de = 1'b1; hit = 5'b10000;
    tick();
    check("pre_rst_grant", grants, 6'b100000);
    cfg_we = 1'b1; cfg_mask = 5'b00001; cfg_div = 8'd7;
    tick();
    cfg_we = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_grants", grants, 6'b0);
    check("async_rst_phase", {4'b0, phase}, 6'd0);
    tick();
    rst = 1'b0;
    hit = 5'b11111;
    tick();
    check("post_rst_grants", grants, 6'b0);
    check("post_rst_phase", {4'b0, phase}, 6'd0);
    pulse_vs();
    check("post_rst_resume", {4'b0, phase}, 6'd1);
    hit = 5'b10000;
    tick();
    check("post_rst_mask", grants, 6'b010000);
    de = 1'b0; hit = '0;
    for (int i = 0; i < 29; i++) pulse_vs();
    check("post_rst_div_hold", {4'b0, phase}, 6'd1);
    pulse_vs();
    check("post_rst_div_toggle", {4'b0, phase}, 6'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
